// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forwarding controller for the 5-stage RV32I pipeline
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic             mem_access,
    input  logic             branch_taken,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             pc_sel_target,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR      = 2'd2;

    localparam logic [15:0]      TIMEOUT_VAL = 16'(MEM_TIMEOUT);
    localparam logic [15:0]      WAIT_ONE    = 16'd1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    logic [1:0]  state;
    logic [15:0] wait_cnt;
    logic        mem_stall;
    logic        load_use;
    logic        in_err;

    assign in_err    = (state == ST_ERR);
    assign mem_err   = in_err;
    assign dmem_req  = mem_access & ~in_err & ~rst;
    assign mem_stall = mem_access & ~dmem_ack;
    assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) |
                        (id_use_rs2 & (id_rs2 == ex_rd)));

    // Reset forces every register to load its zero/bubble value; ERR freezes the whole pipe.
    always_comb begin
        pc_en         = 1'b1;
        pc_sel_target = 1'b0;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        ex_mem_flush  = 1'b0;
        mem_wb_flush  = 1'b0;
        if (rst) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (in_err) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (mem_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (branch_taken) begin
            pc_sel_target = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_flush  = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is never forwarded.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!rst) begin
            if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs1)
                fwd_a = 2'b10;
            else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1)
                fwd_a = 2'b01;
            if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs2)
                fwd_b = 2'b10;
            else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2)
                fwd_b = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= 16'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_stall) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= WAIT_ONE;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ack && dmem_req) begin
                        state    <= ST_RUN;
                        wait_cnt <= 16'd0;
                    end else if (wait_cnt == TIMEOUT_VAL) begin
                        state <= ST_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end
                ST_ERR: state <= ST_ERR;
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= 16'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (!pc_en && !in_err && stall_cycles != CNT_MAX)
            stall_cycles <= stall_cycles + CNT_ONE;
    end

endmodule
